// File: rtl/ccg_func_sig_engine_if.sv
// Stimulus/result bundle for ccg_func_sig_engine: the master drives vectors and start, and the slave returns results.
// f_parity is present only when CCG_PARITY_EN is defined.
interface ccg_func_sig_engine_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 19,
  parameter int SIG_W = 32
);
  logic              start;
  logic [N_IN-1:0]   x_in;
  logic              x_valid;
  logic              x_ready;
  logic [N_OUT-1:0]  f_out;
  logic              f_valid;
  logic              busy;
  logic              done;
  logic [SIG_W-1:0]  signature;
  logic [N_IN:0]     vec_cnt;
`ifdef CCG_PARITY_EN
  logic              f_parity;

  modport master (output start, x_in, x_valid,
                  input  x_ready, f_out, f_valid, f_parity, busy, done, signature, vec_cnt);
  modport slave  (input  start, x_in, x_valid,
                  output x_ready, f_out, f_valid, f_parity, busy, done, signature, vec_cnt);
`else
  modport master (output start, x_in, x_valid,
                  input  x_ready, f_out, f_valid, busy, done, signature, vec_cnt);
  modport slave  (input  start, x_in, x_valid,
                  output x_ready, f_out, f_valid, busy, done, signature, vec_cnt);
`endif
endinterface

// File: rtl/ccg_func_sig_engine.sv
// Gate-family evaluator: results are registered 1 cycle after a vector is applied and compacted into a MISR.
// There is no output backpressure; streaming or a 2^N_IN sweep. CCG_PARITY_EN adds f_parity, which is also folded.
module ccg_func_sig_engine #(
  parameter int               N_IN     = 4,
  parameter int               N_OUT    = 19,
  parameter int               SIG_W    = 32,
  parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(32'h04C11DB7)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ccg_func_sig_engine_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

`ifdef CCG_PARITY_EN
  localparam int FOLD_W = N_OUT + 1;
`else
  localparam int FOLD_W = N_OUT;
`endif
  localparam int N_CHUNK = (FOLD_W + SIG_W - 1) / SIG_W;

  state_t                      r_state;
  logic [N_OUT-1:0]            r_f;
  logic                        r_f_vld;
  logic                        r_busy;
  logic                        r_done;
  logic [SIG_W-1:0]            r_sig;
  logic [N_IN:0]               r_vec_cnt;

  logic                        w_idle;
  logic                        w_apply;
  logic                        w_last;
  logic [N_IN-1:0]             w_x;
  logic [N_OUT-1:0]            w_f;
  logic [FOLD_W-1:0]           w_fold_src;
  logic [N_CHUNK:0][SIG_W-1:0] w_fold_acc;
  logic [SIG_W-1:0]            w_sig_next;

  assign w_idle  = (r_state == S_IDLE);
  assign w_apply = (r_state == S_SWEEP) || (w_idle && bus.x_valid && !bus.start);
  assign w_x     = (r_state == S_SWEEP) ? r_vec_cnt[N_IN-1:0] : bus.x_in;
  assign w_last  = (r_vec_cnt[N_IN-1:0] == {N_IN{1'b1}});

  // Output i gates inputs (i mod N_IN, i+1 mod N_IN); the op cycles every N_IN outputs.
  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_gate
    localparam int A  = gi % N_IN;
    localparam int B  = (gi + 1) % N_IN;
    localparam int OP = (gi / N_IN) % 4;
    if (OP == 0) begin : g_and
      assign w_f[gi] = w_x[A] & w_x[B];
    end else if (OP == 1) begin : g_or
      assign w_f[gi] = w_x[A] | w_x[B];
    end else if (OP == 2) begin : g_xor
      assign w_f[gi] = w_x[A] ^ w_x[B];
    end else begin : g_xnor
      assign w_f[gi] = ~(w_x[A] ^ w_x[B]);
    end
  end

`ifdef CCG_PARITY_EN
  logic r_parity;
  assign w_fold_src   = {r_parity, r_f};
  assign bus.f_parity = r_parity;
`else
  assign w_fold_src = r_f;
`endif

  // The last chunk is zero-extended, which pads the fold source up to a multiple of SIG_W.
  assign w_fold_acc[0] = '0;
  for (genvar gc = 0; gc < N_CHUNK; gc++) begin : g_fold
    localparam int LO = gc * SIG_W;
    localparam int HI = (LO + SIG_W < FOLD_W) ? (LO + SIG_W - 1) : (FOLD_W - 1);
    assign w_fold_acc[gc+1] = w_fold_acc[gc] ^ SIG_W'(w_fold_src[HI:LO]);
  end

  assign w_sig_next = {r_sig[SIG_W-2:0], 1'b0} ^ (r_sig[SIG_W-1] ? SIG_POLY : '0)
                      ^ w_fold_acc[N_CHUNK];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_f       <= '0;
      r_f_vld   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sig     <= '0;
      r_vec_cnt <= '0;
`ifdef CCG_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_f_vld <= w_apply;
      r_done  <= 1'b0;
      if (w_apply) begin
        r_f <= w_f;
`ifdef CCG_PARITY_EN
        r_parity <= ^w_f;
`endif
      end
      // A sweep starts from a clean signature; streaming keeps accumulating.
      if (w_idle && bus.start) begin
        r_sig <= '0;
      end else if (r_f_vld) begin
        r_sig <= w_sig_next;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state   <= S_SWEEP;
            r_busy    <= 1'b1;
            r_vec_cnt <= '0;
          end
        end
        S_SWEEP: begin
          r_vec_cnt <= r_vec_cnt + (N_IN+1)'(1);
          if (w_last) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.x_ready   = w_idle && !bus.start;
  assign bus.f_out     = r_f;
  assign bus.f_valid   = r_f_vld;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.signature = r_sig;
  assign bus.vec_cnt   = r_vec_cnt;
endmodule

// File: tb/tb_ccg_func_sig_engine.sv
// Directed bench for ccg_func_sig_engine using a default instance and an N_IN=3/N_OUT=40/SIG_W=16 instance.
// Expected beats are queued at stimulus time and popped when f_valid appears.
`timescale 1ns/1ps
module tb_ccg_func_sig_engine;
  localparam int AI = 4, AO = 19, AW = 32;
  localparam int BI = 3, BO = 40, BW = 16;
  localparam logic [31:0] A_POLY = 32'h04C11DB7;
  localparam logic [15:0] B_POLY = 16'h8005;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  ccg_func_sig_engine_if #(.N_IN(AI), .N_OUT(AO), .SIG_W(AW)) ifa ();
  ccg_func_sig_engine_if #(.N_IN(BI), .N_OUT(BO), .SIG_W(BW)) ifb ();

  ccg_func_sig_engine #(.N_IN(AI), .N_OUT(AO), .SIG_W(AW), .SIG_POLY(A_POLY))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  ccg_func_sig_engine #(.N_IN(BI), .N_OUT(BO), .SIG_W(BW), .SIG_POLY(B_POLY))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_f(input int n_in, input int n_out, input logic [11:0] x);
    logic [63:0] f;
    logic a, b;
    f = '0;
    for (int i = 0; i < n_out; i++) begin
      a = x[i % n_in];
      b = x[(i + 1) % n_in];
      case ((i / n_in) % 4)
        0:       f[i] = a & b;
        1:       f[i] = a | b;
        2:       f[i] = a ^ b;
        default: f[i] = ~(a ^ b);
      endcase
    end
    return f;
  endfunction

  function automatic logic [63:0] model_misr(input int w, input logic [63:0] poly,
                                             input logic [63:0] sig, input logic [63:0] f,
                                             input int n_out);
    logic [64:0] src;
    logic [63:0] fold, mask;
    int sw;
    src = {1'b0, f};
    sw  = n_out;
`ifdef CCG_PARITY_EN
    src[n_out] = ^f;
    sw = n_out + 1;
`endif
    fold = '0;
    for (int k = 0; k < sw; k++) fold[k % w] ^= src[k];
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    return ((sig << 1) ^ (sig[w-1] ? poly : 64'd0) ^ fold) & mask;
  endfunction

  logic [63:0] qa [$];
  logic [63:0] qb [$];
  logic [63:0] msig_a = '0;
  logic [63:0] msig_b = '0;
  logic        pva = 1'b0, pvb = 1'b0;
  int          beats_a = 0, beats_b = 0;

  // Scoreboard for instance A: pop on each beat, and check the signature once the beat has folded in.
  always @(posedge clk) begin
    logic [63:0] e;
    #1;
    if (!rst_n) begin
      chk("rst_fvld_a", ifa.f_valid, 0);
      qa.delete();
      msig_a = '0;
      pva = 1'b0;
    end else begin
      if (pva) chk("sig_a", ifa.signature, msig_a);
      pva = ifa.f_valid;
      if (ifa.f_valid) begin
        beats_a++;
        n_tests++;
        assert (qa.size() > 0) else begin
          n_fail++;
          $error("FAIL beat_a observed unexpected f_valid, queue size %0d required >0", qa.size());
        end
        if (qa.size() > 0) begin
          e = qa.pop_front();
          chk("f_out_a", ifa.f_out, e);
`ifdef CCG_PARITY_EN
          chk("parity_a", ifa.f_parity, ^e);
`endif
          msig_a = model_misr(AW, A_POLY, msig_a, e, AO);
        end
      end
    end
  end

  always @(posedge clk) begin
    logic [63:0] e;
    #1;
    if (!rst_n) begin
      chk("rst_fvld_b", ifb.f_valid, 0);
      qb.delete();
      msig_b = '0;
      pvb = 1'b0;
    end else begin
      if (pvb) chk("sig_b", ifb.signature, msig_b);
      pvb = ifb.f_valid;
      if (ifb.f_valid) begin
        beats_b++;
        n_tests++;
        assert (qb.size() > 0) else begin
          n_fail++;
          $error("FAIL beat_b observed unexpected f_valid, queue size %0d required >0", qb.size());
        end
        if (qb.size() > 0) begin
          e = qb.pop_front();
          chk("f_out_b", ifb.f_out, e);
`ifdef CCG_PARITY_EN
          chk("parity_b", ifb.f_parity, ^e);
`endif
          msig_b = model_misr(BW, {48'd0, B_POLY}, msig_b, e, BO);
        end
      end
    end
  end

  task automatic stream_a(input logic [3:0] x, input logic [18:0] f_exp, input logic [31:0] s_exp);
    @(negedge clk);
    ifa.x_in    = x;
    ifa.x_valid = 1'b1;
    #1 chk("stream_x_ready", ifa.x_ready, 1);
    qa.push_back(model_f(AI, AO, {8'd0, x}));
    @(negedge clk);
    ifa.x_valid = 1'b0;
    chk("stream_fvld", ifa.f_valid, 1);
    chk("stream_fout", ifa.f_out, f_exp);
    @(negedge clk);
    chk("stream_sig", ifa.signature, s_exp);
  endtask

  task automatic sweep_a(input bit hold_x, input logic [63:0] s_exp);
    int nb = 0, first = -1, last = -1, dn = 0;
    @(negedge clk);
    ifa.start   = 1'b1;
    ifa.x_valid = hold_x;
    ifa.x_in    = 4'hA;
    #1 chk("start_x_ready", ifa.x_ready, 0);
    msig_a = '0;
    for (int v = 0; v < 16; v++) qa.push_back(model_f(AI, AO, 12'(v)));
    @(negedge clk);
    ifa.start = 1'b0;
    chk("sweep_busy", ifa.busy, 1);
    for (int c = 0; c < 60 && ifa.busy; c++) begin
      chk("sweep_x_ready", ifa.x_ready, 0);
      if (ifa.f_valid) begin
        nb++;
        if (first < 0) first = c;
        last = c;
      end
      if (ifa.done) begin
        dn++;
        ifa.x_valid = 1'b0;
      end
      @(negedge clk);
    end
    ifa.x_valid = 1'b0;
    chk("sweep_beats", nb, 16);
    chk("sweep_consecutive", last - first + 1, 16);
    chk("sweep_done_pulses", dn, 1);
    chk("sweep_busy_end", ifa.busy, 0);
    chk("sweep_vec_cnt", ifa.vec_cnt, 16);
    chk("sweep_sig", ifa.signature, s_exp);
    chk("sweep_queue_empty", qa.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    logic [63:0] exp_sweep_a, exp_sweep_b;
    logic [3:0]  x;
    int          c, dn, nb;

    ifa.start = 1'b0; ifa.x_valid = 1'b0; ifa.x_in = '0;
    ifb.start = 1'b0; ifb.x_valid = 1'b0; ifb.x_in = '0;
    exp_sweep_a = '0;
    for (int v = 0; v < 16; v++)
      exp_sweep_a = model_misr(AW, A_POLY, exp_sweep_a, model_f(AI, AO, 12'(v)), AO);
    exp_sweep_b = '0;
    for (int v = 0; v < 8; v++)
      exp_sweep_b = model_misr(BW, {48'd0, B_POLY}, exp_sweep_b, model_f(BI, BO, 12'(v)), BO);

    repeat (3) @(negedge clk);
    chk("rst_f_out", ifa.f_out, 0);
    chk("rst_done", ifa.done, 0);
    chk("rst_sig", ifa.signature, 0);
    chk("rst_vec_cnt", ifa.vec_cnt, 0);
    chk("rst_busy", ifa.busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_x_ready", ifa.x_ready, 1);

    stream_a(4'b0101, 19'h00FF0, 32'h00000FF0);
    stream_a(4'b1111, 19'h7F0FF, 32'h0007EF1F);

    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      x = 4'($urandom_range(0, 15));
      ifa.x_in    = x;
      ifa.x_valid = 1'b1;
      qa.push_back(model_f(AI, AO, {8'd0, x}));
    end
    @(negedge clk);
    ifa.x_valid = 1'b0;
    @(negedge clk);

    sweep_a(1'b0, exp_sweep_a);
    sweep_a(1'b1, exp_sweep_a);

    // Reset in the middle of a sweep.
    @(negedge clk);
    ifa.start = 1'b1;
    msig_a = '0;
    for (int v = 0; v < 16; v++) qa.push_back(model_f(AI, AO, 12'(v)));
    @(negedge clk);
    ifa.start = 1'b0;
    c = 0;
    while (ifa.vec_cnt != 7 && c < 40) begin
      @(negedge clk);
      c++;
    end
    chk("reach_vec7", ifa.vec_cnt, 7);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_f_out", ifa.f_out, 0);
    chk("mid_rst_fvld", ifa.f_valid, 0);
    chk("mid_rst_done", ifa.done, 0);
    chk("mid_rst_sig", ifa.signature, 0);
    chk("mid_rst_vec_cnt", ifa.vec_cnt, 0);
    chk("mid_rst_busy", ifa.busy, 0);
    rst_n = 1'b1;
    dn = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ifa.done || ifa.f_valid) dn++;
    end
    chk("post_rst_quiet", dn, 0);
    sweep_a(1'b0, exp_sweep_a);

    // Narrow configuration: three 16-bit fold chunks.
    @(negedge clk);
    ifb.start = 1'b1;
    msig_b = '0;
    for (int v = 0; v < 8; v++) qb.push_back(model_f(BI, BO, 12'(v)));
    @(negedge clk);
    ifb.start = 1'b0;
    nb = beats_b;
    dn = 0;
    c = 0;
    while (ifb.busy && c < 40) begin
      if (ifb.done) dn++;
      @(negedge clk);
      c++;
    end
    chk("b_beats", beats_b - nb, 8);
    chk("b_done_pulses", dn, 1);
    chk("b_vec_cnt", ifb.vec_cnt, 8);
    chk("b_sig", ifb.signature, exp_sweep_b);
    chk("b_queue_empty", qb.size(), 0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
